// File: rtl/sa_fifo_pkg.sv
// Shared constants and helpers for the 80x36 systolic-array FIFO controller.
package sa_fifo_pkg;

    localparam int SA_FIFO_DEPTH = 80;
    localparam int SA_FIFO_WIDTH = 36;
    localparam int SA_FIFO_PTR_W = 7;
    localparam int SA_FIFO_CNT_W = 7;

    // Advance a RAM pointer, wrapping at the non-power-of-two depth.
    function automatic logic [SA_FIFO_PTR_W-1:0] ptr_inc(input logic [SA_FIFO_PTR_W-1:0] p);
        return (p == SA_FIFO_PTR_W'(SA_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/sa_ram_rwsthp_80x36.sv
// Behavioural view of the 80x36 two-port RAM macro: registered read address,
// registered output with a bypass mux in front of the output register.
module sa_ram_rwsthp_80x36
    import sa_fifo_pkg::*;
(
    input  logic                     clk,
    input  logic [SA_FIFO_PTR_W-1:0] ra,
    input  logic                     re,
    input  logic                     ore,
    output logic [SA_FIFO_WIDTH-1:0] dout,
    input  logic [SA_FIFO_PTR_W-1:0] wa,
    input  logic                     we,
    input  logic [SA_FIFO_WIDTH-1:0] di,
    input  logic                     byp_sel,
    input  logic [SA_FIFO_WIDTH-1:0] dbyp,
    input  logic [31:0]              pwrbus_ram_pd
);

    logic [SA_FIFO_WIDTH-1:0] r_mem [0:SA_FIFO_DEPTH-1];
    logic [SA_FIFO_PTR_W-1:0] r_ra_d;
    logic [SA_FIFO_WIDTH-1:0] r_dout;
    logic                     w_unused_pd;

    // Power-bus control only matters to the physical macro.
    assign w_unused_pd = ^pwrbus_ram_pd;

    // Write port.
    // NOTE: the storage array has no reset; its contents are meaningless until written and resetting it would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wa] <= di;
        end
    end

    // Read address register; holds while re is low.
    always_ff @(posedge clk) begin
        if (re) begin
            r_ra_d <= ra;
        end
    end

    // Output register, loaded from the array or the bypass input; holds while ore is low.
    always_ff @(posedge clk) begin
        if (ore) begin
            r_dout <= byp_sel ? dbyp : r_mem[r_ra_d];
        end
    end

    assign dout = r_dout;

endmodule

// File: rtl/sa_fifo_ctrl_80x36.sv
// FIFO controller sequencing one 80x36 RAM macro behind valid/ready push and
// pop ports. Capacity is 81 words: 80 in the array plus the RAM output register.
module sa_fifo_ctrl_80x36
    import sa_fifo_pkg::*;
#(
    parameter int DEPTH = SA_FIFO_DEPTH,
    parameter int WIDTH = SA_FIFO_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [SA_FIFO_CNT_W-1:0] count,
    input  logic [31:0]              pwrbus_ram_pd
);

    // Registered state.
    logic [SA_FIFO_PTR_W-1:0] r_wr_ptr;
    logic [SA_FIFO_PTR_W-1:0] r_rd_ptr;
    logic [SA_FIFO_CNT_W-1:0] r_used;      // written into RAM, not yet captured
    logic                     r_s1_valid;  // read address latched, data not yet captured
    logic                     r_out_valid; // output register holds the head

    // Per-cycle decisions.
    logic                     w_push;
    logic                     w_pop;
    logic                     w_byp;
    logic                     w_we;
    logic                     w_cap;
    logic                     w_iss;
    logic                     w_ore;
    logic                     w_byp_sel;
    logic [SA_FIFO_CNT_W-1:0] w_ram_pending;
    logic [SA_FIFO_PTR_W-1:0] w_wa;
    logic [SA_FIFO_PTR_W-1:0] w_ra;

    // in_ready comes from registers only, so a pop never frees a push slot in the same cycle.
    assign in_ready = (r_used != SA_FIFO_CNT_W'(DEPTH));
    assign w_push   = in_valid && in_ready;
    assign w_pop    = r_out_valid && out_ready;

    // Cut-through: nothing in the RAM and the output slot is free this cycle.
    assign w_byp     = w_push && (r_used == '0) && (!r_out_valid || w_pop);
    assign w_we      = w_push && !w_byp;
    assign w_cap     = r_s1_valid && (!r_out_valid || w_pop);
    // Entries written but not yet issued for read.
    assign w_ram_pending = r_used - {{(SA_FIFO_CNT_W-1){1'b0}}, r_s1_valid};
    assign w_iss     = (w_ram_pending != '0) && (!r_s1_valid || w_cap);
    assign w_ore     = w_byp || w_cap;
    assign w_byp_sel = w_byp;
    assign w_wa      = r_wr_ptr;
    assign w_ra      = r_rd_ptr;

    assign count     = r_used + {{(SA_FIFO_CNT_W-1){1'b0}}, r_out_valid};
    assign out_valid = r_out_valid;

    // Pointer, occupancy and pipeline-stage bookkeeping.
    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_used      <= '0;
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_we) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_iss) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            // An entry is released only when its data reaches the output register.
            case ({w_we, w_cap})
                2'b10:   r_used <= r_used + 1'b1;
                2'b01:   r_used <= r_used - 1'b1;
                default: r_used <= r_used;
            endcase
            r_s1_valid  <= w_iss || (r_s1_valid && !w_cap);
            r_out_valid <= w_byp || w_cap || (r_out_valid && !w_pop);
        end
    end

    sa_ram_rwsthp_80x36 u_ram (
        .clk           (clk),
        .ra            (w_ra),
        .re            (w_iss),
        .ore           (w_ore),
        .dout          (out_data),
        .wa            (w_wa),
        .we            (w_we),
        .di            (in_data),
        .byp_sel       (w_byp_sel),
        .dbyp          (in_data),
        .pwrbus_ram_pd (pwrbus_ram_pd)
    );

endmodule
